// File: rtl/ps2_pad_pkg.sv
// ps2_pad_pkg: shared protocol constants and FSM state type for the PS2 pad responder.
package ps2_pad_pkg;
    localparam logic [7:0] PS2_CMD_START   = 8'h01;
    localparam logic [7:0] PS2_CMD_POLL    = 8'h42;
    localparam logic [7:0] PS2_BYTE_IDLE   = 8'hFF;
    localparam logic [7:0] PS2_BYTE_READY  = 8'h5A;
    localparam int         PS2_FRAME_BYTES = 9;
    localparam logic [7:0] PS2_AXIS_CENTRE = 8'h80;

    typedef enum logic [1:0] {IDLE, XFER, IGNORE, DONE} ps2_state_e;
endpackage

// File: rtl/ps2_pad_sync.sv
// ps2_pad_sync: multi-bit level synchronizer plus a separately synchronized sclk with edge detect.
module ps2_pad_sync #(
    parameter int W      = 2,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         sclk,
    output logic [W-1:0] dout,
    output logic         sclk_rise,
    output logic         sclk_fall
);
    logic [W-1:0]      chain [STAGES];
    logic [STAGES-1:0] sclk_chain;
    logic              sclk_d;

    // Level chain resets low so a host already holding att low never looks like a fresh fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
            sclk_chain <= '1;
            sclk_d     <= 1'b1;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            sclk_chain <= {sclk_chain[STAGES-2:0], sclk};
            sclk_d     <= sclk_chain[STAGES-1];
        end
    end

    assign dout      = chain[STAGES-1];
    assign sclk_rise = sclk_chain[STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_chain[STAGES-1] & sclk_d;
endmodule

// File: rtl/ps2_pad_responder.sv
// ps2_pad_responder: pad-side PS2 link answering a host poll with a 9-byte analog frame.
// Define PS2_PAD_ACK_EN to build the per-byte ack_n generator; otherwise ack_n is tied high.
module ps2_pad_responder
    import ps2_pad_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] PAD_ID      = 8'h73,
    parameter int         ACK_DLY     = 480,
    parameter int         ACK_LEN     = 160
) (
    input  logic        CLK_40M,
    input  logic        rst,
    input  logic        att,
    input  logic        sclk_in,
    input  logic        cmd_in,
    input  logic [15:0] btn_n,
    input  logic [7:0]  stick_rx,
    input  logic [7:0]  stick_ry,
    input  logic [7:0]  stick_lx,
    input  logic [7:0]  stick_ly,
    output logic        dat_out,
    output logic        ack_n,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);
    ps2_state_e  state;
    logic [1:0]  sync_q;
    logic        att_s, cmd_s, att_d, att_rise, att_fall, sclk_rise, sclk_fall;
    logic [2:0]  bit_idx;
    logic [3:0]  byte_idx;
    logic [7:0]  tx_byte, tx_next, rx_next;
    logic [6:0]  rx_byte;
    logic [15:0] snap_btn;
    logic [7:0]  snap_rx, snap_ry, snap_lx, snap_ly;
    logic        byte_end, reject, last_byte;

    ps2_pad_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync (
        .clk(CLK_40M), .rst(rst), .din({att, cmd_in}), .sclk(sclk_in),
        .dout(sync_q), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall)
    );

    assign att_s    = sync_q[1];
    assign cmd_s    = sync_q[0];
    assign att_rise = att_s & ~att_d;
    assign att_fall = ~att_s & att_d;

    // The 8th command bit is taken straight from the pin so the byte is judged on that same edge.
    assign rx_next   = {cmd_s, rx_byte};
    assign byte_end  = state == XFER && sclk_rise && bit_idx == 3'd7;
    assign last_byte = byte_idx == 4'(PS2_FRAME_BYTES - 1);
    assign reject    = byte_end && (byte_idx == 4'd0 ? rx_next != PS2_CMD_START :
                                    byte_idx == 4'd1 ? rx_next != PS2_CMD_POLL  : 1'b0);

    always_comb begin
        tx_next = byte_idx == 4'd0 ? PAD_ID :
                  byte_idx == 4'd1 ? PS2_BYTE_READY :
                  byte_idx == 4'd2 ? snap_btn[7:0] :
                  byte_idx == 4'd3 ? snap_btn[15:8] :
                  byte_idx == 4'd4 ? snap_rx :
                  byte_idx == 4'd5 ? snap_ry :
                  byte_idx == 4'd6 ? snap_lx : snap_ly;
    end

    always_ff @(posedge CLK_40M or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            att_d      <= 1'b0;
            dat_out    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            tx_byte    <= PS2_BYTE_IDLE;
            rx_byte    <= '0;
            snap_btn   <= '1;
            snap_rx    <= PS2_AXIS_CENTRE;
            snap_ry    <= PS2_AXIS_CENTRE;
            snap_lx    <= PS2_AXIS_CENTRE;
            snap_ly    <= PS2_AXIS_CENTRE;
        end else begin
            att_d      <= att_s;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (att_rise) begin
                state     <= IDLE;
                dat_out   <= 1'b1;
                busy      <= 1'b0;
                bit_idx   <= '0;
                byte_idx  <= '0;
                frame_err <= state == XFER;
            end else begin
                case (state)
                    IDLE: if (att_fall) begin
                        snap_btn <= btn_n;
                        snap_rx  <= stick_rx;
                        snap_ry  <= stick_ry;
                        snap_lx  <= stick_lx;
                        snap_ly  <= stick_ly;
                        tx_byte  <= PS2_BYTE_IDLE;
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                    XFER: begin
                        if (sclk_fall) dat_out <= tx_byte[bit_idx];
                        if (sclk_rise) begin
                            rx_byte <= {cmd_s, rx_byte[6:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                        if (reject) begin
                            frame_err <= 1'b1;
                            dat_out   <= 1'b1;
                            state     <= IGNORE;
                        end else if (byte_end && last_byte) begin
                            frame_done <= 1'b1;
                            dat_out    <= 1'b1;
                            state      <= DONE;
                        end else if (byte_end) begin
                            byte_idx <= byte_idx + 4'd1;
                            tx_byte  <= tx_next;
                        end
                    end
                    default: dat_out <= 1'b1;
                endcase
            end
        end
    end

`ifdef PS2_PAD_ACK_EN
    localparam int AW = $clog2(ACK_DLY + ACK_LEN + 1);
    logic [AW-1:0] ack_cnt;
    logic          ack_run, ack_go;

    assign ack_go = byte_end && !reject && !last_byte && !att_rise;

    // A byte completing mid-ack restarts the window; sclk edges alone never cancel it.
    always_ff @(posedge CLK_40M or posedge rst) begin
        if (rst) begin
            ack_n   <= 1'b1;
            ack_run <= 1'b0;
            ack_cnt <= '0;
        end else if (att_rise) begin
            ack_n   <= 1'b1;
            ack_run <= 1'b0;
            ack_cnt <= '0;
        end else if (ack_go) begin
            ack_run <= 1'b1;
            ack_cnt <= '0;
        end else if (ack_run) begin
            ack_cnt <= ack_cnt + 1'b1;
            if (ack_cnt == AW'(ACK_DLY - 1)) ack_n <= 1'b0;
            if (ack_cnt == AW'(ACK_DLY + ACK_LEN - 1)) begin
                ack_n   <= 1'b1;
                ack_run <= 1'b0;
            end
        end
    end
`else
    assign ack_n = 1'b1;
`endif
endmodule

// File: tb/tb_ps2_pad_responder.sv
// tb_ps2_pad_responder: host-side poll driver with a frame-level reference model of the pad reply.
module tb_ps2_pad_responder;
    localparam int H = 8;
`ifdef PS2_PAD_ACK_EN
    localparam bit ACK_ON = 1'b1;
    localparam int GAP    = 660;
    localparam int NRAND  = 2;
`else
    localparam bit ACK_ON = 1'b0;
    localparam int GAP    = 16;
    localparam int NRAND  = 20;
`endif

    logic        CLK_40M = 1'b0;
    logic        rst = 1'b0, att = 1'b1, sclk_in = 1'b1, cmd_in = 1'b1;
    logic [15:0] btn_n = '1;
    logic [7:0]  stick_rx = 8'h80, stick_ry = 8'h80, stick_lx = 8'h80, stick_ly = 8'h80;
    logic        dat_out, ack_n, busy, frame_done, frame_err;

    ps2_pad_responder dut (
        .CLK_40M(CLK_40M), .rst(rst), .att(att), .sclk_in(sclk_in), .cmd_in(cmd_in),
        .btn_n(btn_n), .stick_rx(stick_rx), .stick_ry(stick_ry), .stick_lx(stick_lx),
        .stick_ly(stick_ly), .dat_out(dat_out), .ack_n(ack_n), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 CLK_40M = ~CLK_40M;

    int vectors = 0, miscompares = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, ack_cnt = 0, fall_cyc = 0, last_rise = 0;
    logic ack_prev = 1'b1;
    logic [7:0] last_rx [9];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK_40M) cyc++;

    always @(negedge CLK_40M) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (ack_prev === 1'b1 && ack_n === 1'b0) begin
            ack_cnt++;
            fall_cyc = cyc;
`ifdef PS2_PAD_ACK_EN
            // ACK_DLY plus two synchronizer stages plus the registering cycle
            check("ack_delay", cyc - last_rise, 480 + 2 + 1);
`endif
        end
`ifdef PS2_PAD_ACK_EN
        if (ack_prev === 1'b0 && ack_n === 1'b1) check("ack_len", cyc - fall_cyc, 160);
`endif
        ack_prev = ack_n;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_40M);
    endtask

    function automatic logic [47:0] pad_now();
        return {btn_n, stick_rx, stick_ry, stick_lx, stick_ly};
    endfunction

    task automatic host_byte(input logic [7:0] c, output logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            sclk_in = 1'b0;
            cmd_in  = c[i];
            tick(H);
            r[i]    = dat_out;
            sclk_in = 1'b1;
            if (i == 7) last_rise = cyc;
            tick(H);
        end
        tick(GAP);
    endtask

    // abort_at = number of bytes clocked before att rises (9 = full frame); mid replaces pad inputs before byte 3.
    task automatic run_frame(input logic [7:0] c0, input logic [7:0] c1, input int abort_at,
                             input bit use_rst, input logic [47:0] mid, input string name);
        logic [7:0] snap [9];
        logic [7:0] got, exp;
        bit ok0, ok1, done_exp, err_exp;
        int d0, e0, a0, ncomp, nacc;
        snap = '{8'hFF, 8'h73, 8'h5A, btn_n[7:0], btn_n[15:8], stick_rx, stick_ry, stick_lx, stick_ly};
        ok0 = c0 == 8'h01;
        ok1 = ok0 && c1 == 8'h42;
        d0 = done_cnt; e0 = err_cnt; a0 = ack_cnt; ncomp = 0;
        att = 1'b0;
        tick(6);
        check({name, "_busy"}, busy, 1);
        for (int b = 0; b < 9; b++) begin
            if (b == 3) {btn_n, stick_rx, stick_ry, stick_lx, stick_ly} = mid;
            if (b == abort_at) begin
                if (use_rst) begin
                    sclk_in = 1'b0;
                    cmd_in  = 1'b0;
                    tick(H);
                    rst = 1'b1;
                    #1;
                    check({name, "_rst_dat"}, dat_out, 1);
                    check({name, "_rst_busy"}, busy, 0);
                    check({name, "_rst_ack"}, ack_n, 1);
                    @(negedge CLK_40M);
                    rst = 1'b0;
                    sclk_in = 1'b1;
                    tick(H);
                end
                break;
            end
            host_byte(b == 0 ? c0 : b == 1 ? c1 : 8'($urandom), got);
            ncomp++;
            exp = b == 0 ? 8'hFF : b == 1 ? (ok0 ? 8'h73 : 8'hFF) : (ok1 ? snap[b] : 8'hFF);
            last_rx[b] = got;
            check($sformatf("%s_b%0d", name, b), got, exp);
        end
        att = 1'b1;
        cmd_in = 1'b1;
        tick(8);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_dat"}, dat_out, 1);
        done_exp = ncomp == 9 && ok1;
        err_exp  = use_rst ? ((!ok0 && ncomp >= 1) || (ok0 && !ok1 && ncomp >= 2)) : !done_exp;
        nacc = 0;
        for (int b = 0; b < ncomp && b < 8; b++) nacc += (b == 0 ? ok0 : ok1) ? 1 : 0;
        check({name, "_done"}, done_cnt - d0, done_exp ? 1 : 0);
        check({name, "_err"}, err_cnt - e0, err_exp ? 1 : 0);
        check({name, "_acks"}, ack_cnt - a0, ACK_ON ? nacc : 0);
    endtask

    initial begin
        logic [7:0] c0, c1;
        int ab;
        #1 rst = 1'b1;
        tick(3);
        check("rst_dat", dat_out, 1);
        check("rst_ack", ack_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b0;
        tick(5);

        btn_n = 16'h5FFF; stick_rx = 8'h12; stick_ry = 8'h34; stick_lx = 8'hAB; stick_ly = 8'hCD;
        run_frame(8'h01, 8'h42, 9, 1'b0, pad_now(), "poll");
        check("circle", !last_rx[4][5], 1);
        check("square", !last_rx[4][7], 1);
        run_frame(8'h81, 8'h42, 9, 1'b0, pad_now(), "bad_start");
        run_frame(8'h01, 8'h43, 9, 1'b0, pad_now(), "bad_cmd");
        run_frame(8'h01, 8'h42, 5, 1'b0, pad_now(), "abort");
        run_frame(8'h01, 8'h42, 9, 1'b0, pad_now(), "after_abort");
        stick_lx = 8'h10;
        run_frame(8'h01, 8'h42, 9, 1'b0, {btn_n, stick_rx, stick_ry, 8'h90, stick_ly}, "lx_change");
        check("lx_snap", last_rx[7], 8'h10);
        run_frame(8'h01, 8'h42, 9, 1'b0, pad_now(), "lx_next");
        check("lx_new", last_rx[7], 8'h90);
        run_frame(8'h01, 8'h42, 6, 1'b1, pad_now(), "rst_mid");
        run_frame(8'h01, 8'h42, 9, 1'b0, pad_now(), "after_rst");

        for (int n = 0; n < NRAND; n++) begin
            {btn_n, stick_rx, stick_ry, stick_lx, stick_ly} = {$urandom, $urandom};
            c0 = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h01;
            c1 = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h42;
            ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 8)) : 9;
            run_frame(c0, c1, ab, 1'b0, {$urandom, $urandom}, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
